// File: rtl/sr_trace_buffer.sv
// Instruction-trace capture buffer with PC-match trigger and cycle watchdog.
// Optional per-entry cycle stamp: define SR_TRACE_CYCLE_STAMP_EN.
module sr_trace_buffer #(
    parameter int DEPTH          = 16,
    parameter int POST_TRIG      = 4,
    parameter int TIMEOUT_CYCLES = 500,
    parameter int STAMP_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid,
    input  logic [31:0]              pc,
    input  logic [31:0]              instr,
    input  logic                     trig_en,
    input  logic [31:0]              trig_pc,
    input  logic                     rearm,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_instr,
`ifdef SR_TRACE_CYCLE_STAMP_EN
    output logic [STAMP_W-1:0]       rd_stamp,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic                     trig_hit,
    output logic                     timeout,
    output logic [31:0]              cycle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] POST_INIT = 32'(POST_TRIG);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STAMP_W < 1) begin : g_bad_param
        $error("sr_trace_buffer: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        POST   = 2'd1,
        FROZEN = 2'd2
    } st_t;

    st_t            st;
    logic [AW-1:0]  wr_ptr;
    logic [31:0]    post_cnt;

    logic [31:0]    mem_pc    [DEPTH];
    logic [31:0]    mem_instr [DEPTH];
`ifdef SR_TRACE_CYCLE_STAMP_EN
    logic [STAMP_W-1:0] mem_stamp [DEPTH];
`endif

    logic          live;
    logic          cap;
    logic          trig;
    logic          wd_hit;
    logic          post_done;
    logic          freeze;
    logic [AW-1:0] rd_idx;
    logic          rd_oob;

    assign live      = (st != FROZEN);
    assign cap       = live && valid && !rst && !rearm;
    assign trig      = live && valid && (st == ARMED) && trig_en && (pc == trig_pc);
    assign wd_hit    = (TIMEOUT_CYCLES != 0) && live && (cycle == WD_LAST);
    assign post_done = valid && (st == POST) && (post_cnt == 32'd1);
    assign freeze    = wd_hit || post_done || (trig && POST_TRIG == 0);
    assign rd_idx    = wr_ptr - count[AW-1:0] + rd_addr;
    assign rd_oob    = ({1'b0, rd_addr} >= count);
    assign state     = st;

    always_ff @(posedge clk) begin
        if (rst || rearm) begin
            st       <= ARMED;
            count    <= '0;
            wr_ptr   <= '0;
            cycle    <= '0;
            trig_hit <= 1'b0;
            timeout  <= 1'b0;
            post_cnt <= '0;
        end else if (live) begin
            if (cycle != 32'hFFFF_FFFF)
                cycle <= cycle + 32'd1;
            if (valid) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count != FULL)
                    count <= count + 1'b1;
            end
            if (wd_hit)
                timeout <= 1'b1;
            if (trig) begin
                trig_hit <= 1'b1;
                post_cnt <= POST_INIT;
            end else if (valid && st == POST) begin
                post_cnt <= post_cnt - 32'd1;
            end
            if (freeze)
                st <= FROZEN;
            else if (trig)
                st <= POST;
        end
    end

    // Trace RAM is deliberately not reset so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (cap) begin
            mem_pc[wr_ptr]    <= pc;
            mem_instr[wr_ptr] <= instr;
`ifdef SR_TRACE_CYCLE_STAMP_EN
            mem_stamp[wr_ptr] <= cycle[STAMP_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pc    <= '0;
            rd_instr <= '0;
`ifdef SR_TRACE_CYCLE_STAMP_EN
            rd_stamp <= '0;
`endif
        end else if (rd_oob) begin
            rd_pc    <= '0;
            rd_instr <= '0;
`ifdef SR_TRACE_CYCLE_STAMP_EN
            rd_stamp <= '0;
`endif
        end else begin
            rd_pc    <= mem_pc[rd_idx];
            rd_instr <= mem_instr[rd_idx];
`ifdef SR_TRACE_CYCLE_STAMP_EN
            rd_stamp <= mem_stamp[rd_idx];
`endif
        end
    end

endmodule
